// File: rtl/bip2_fetch_pkg.sv
// Shared types for the instruction-ROM fetch controller.
// Holds the FSM state enum, prefetch depth and buffer entry layout.
package bip2_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int FETCH_DEPTH  = 2;
   localparam int FETCH_ADDR_W = 11;
   localparam int FETCH_DATA_W = 16;

   // Entry layout at the default widths; the controller builds
   // the same {pc, instr} layout at its own parameter widths.
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer of {pc, instr} with synchronous flush.
// Ports: clk, rst_n (sync, active-low), flush, push, din, pop,
//        head (oldest entry), valid (non-empty), count (0..2).
module fetch_fifo
   import bip2_fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  entry_t     din,
   input  logic       pop,
   output entry_t     head,
   output logic       valid,
   output logic [1:0] count
);

   entry_t mem [FETCH_DEPTH];
   logic   wr_ptr;
   logic   rd_ptr;

   assign head  = mem[rd_ptr];
   assign valid = (count != 2'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FETCH_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALT FSM, PC, 2-deep prefetch.
// Ports: CLK_i, RST_n_i (sync, active-low), START_i, HALT_i,
//        BR_VALID_i/BR_ADDR_i (redirect), ADDR_im_o/DATA_im_i (async ROM),
//        INSTR_o/INSTR_PC_o/INSTR_VALID_o/INSTR_READY_i (decoder side),
//        STATE_o. Macro ROM_FETCH_DBG_EN adds DBG_REQ_i, DBG_ADDR_i,
//        DBG_ACK_o, DBG_DATA_o sharing the ROM via round-robin.
module rom_fetch_ctrl
   import bip2_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 11,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK_i,
   input  logic              RST_n_i,
   input  logic              START_i,
   input  logic              HALT_i,
   input  logic              BR_VALID_i,
   input  logic [ADDR_W-1:0] BR_ADDR_i,
   output logic [ADDR_W-1:0] ADDR_im_o,
   input  logic [DATA_W-1:0] DATA_im_i,
   output logic [DATA_W-1:0] INSTR_o,
   output logic [ADDR_W-1:0] INSTR_PC_o,
   output logic              INSTR_VALID_o,
   input  logic              INSTR_READY_i,
`ifdef ROM_FETCH_DBG_EN
   input  logic              DBG_REQ_i,
   input  logic [ADDR_W-1:0] DBG_ADDR_i,
   output logic              DBG_ACK_o,
   output logic [DATA_W-1:0] DBG_DATA_o,
`endif
   output logic [1:0]        STATE_o
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              fetch_want;
   logic              fetch;
   logic              pop;
   logic [1:0]        count;
   entry_t            din;
   entry_t            head;

   // Redirect blocks the pop so the flushed head is never consumed.
   assign pop = INSTR_VALID_o && INSTR_READY_i && !BR_VALID_i;

   assign fetch_want = (state == RUN) && !BR_VALID_i &&
                       ((count < 2'(FETCH_DEPTH)) || pop);

`ifdef ROM_FETCH_DBG_EN
   logic dbg_grant;
   logic rr_dbg;

   // rr_dbg marks whose turn it is on contention; debug wins first.
   assign dbg_grant = DBG_REQ_i && (!fetch_want || rr_dbg);
   assign fetch     = fetch_want && !dbg_grant;
   assign ADDR_im_o = dbg_grant ? DBG_ADDR_i : pc;

   always_ff @(posedge CLK_i) begin
      if (!RST_n_i) begin
         rr_dbg     <= 1'b1;
         DBG_ACK_o  <= 1'b0;
         DBG_DATA_o <= '0;
      end else begin
         DBG_ACK_o <= dbg_grant;
         if (dbg_grant) begin
            DBG_DATA_o <= DATA_im_i;
         end
         if (DBG_REQ_i && fetch_want) begin
            rr_dbg <= !dbg_grant;
         end
      end
   end
`else
   assign fetch     = fetch_want;
   assign ADDR_im_o = pc;
`endif

   assign din = {pc, DATA_im_i};

   always_ff @(posedge CLK_i) begin
      if (!RST_n_i) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         IDLE:    if (!BR_VALID_i && START_i) state_nxt = RUN;
         RUN:     if (!BR_VALID_i && HALT_i) state_nxt = HALT;
         HALT:    if (!BR_VALID_i && START_i && !HALT_i) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      if (BR_VALID_i) begin
         pc_nxt = BR_ADDR_i;
      end else if (fetch) begin
         pc_nxt = pc + ADDR_W'(1);
      end
   end

   fetch_fifo #(
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (CLK_i),
      .rst_n (RST_n_i),
      .flush (BR_VALID_i),
      .push  (fetch),
      .din   (din),
      .pop   (pop),
      .head  (head),
      .valid (INSTR_VALID_o),
      .count (count)
   );

   assign INSTR_o    = head.instr;
   assign INSTR_PC_o = head.pc;
   assign STATE_o    = state;

endmodule
